// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-host memory arbiter.
package rom_arb_pkg;

  typedef enum logic {
    HOST_A = 1'b0,
    HOST_B = 1'b1
  } host_e;

  localparam logic [31:0] DefMemBase = 32'h0000_0000;
  localparam int unsigned DefMemSize = 8192;

  // Bits needed to index a 32-bit word inside the default window.
  localparam int unsigned WordIdxW = $clog2(DefMemSize / 4);

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: round-robin on contention, or fixed priority to host A.
module rr_arb2
  import rom_arb_pkg::*;
#(
  parameter bit FixedPrio = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  host_e prio_q;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && req_b) begin
      if (FixedPrio || prio_q == HOST_A) gnt_a = 1'b1;
      else                               gnt_b = 1'b1;
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

  // Pointer only moves on contention, and then names the loser.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= HOST_A;
    end else if (req_a && req_b) begin
      prio_q <= gnt_a ? HOST_B : HOST_A;
    end
  end

endmodule

// File: rtl/rom_1p_arbiter.sv
// Arbitrates an instruction-fetch host and a data host onto one fixed-latency
// memory, checks range/permission locally and routes responses to their owner.
module rom_1p_arbiter
  import rom_arb_pkg::*;
#(
  parameter logic [31:0] MemBase   = DefMemBase,
  parameter int unsigned MemSize   = DefMemSize,
  parameter bit          ReadOnly  = 1'b0,
  parameter bit          FixedPrio = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        a_req_i,
  input  logic [31:0] a_addr_i,
  output logic        a_gnt_o,
  output logic        a_rvalid_o,
  output logic [31:0] a_rdata_o,
  output logic        a_err_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [3:0]  b_be_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic        b_gnt_o,
  output logic        b_rvalid_o,
  output logic [31:0] b_rdata_o,
  output logic        b_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        proto_err_o
);

  logic        gnt_a, gnt_b, any_gnt;
  logic [31:0] addr, offset;
  logic        we, in_range, acc_err;
  logic        pend_q, lerr_q, wr_q, proto_q;
  host_e       owner_q;
  logic        fwd_rsp, rsp_valid;
  logic [31:0] rsp_data;

  rr_arb2 #(.FixedPrio(FixedPrio)) u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_a (a_req_i),
    .req_b (b_req_i),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign a_gnt_o = gnt_a;
  assign b_gnt_o = gnt_b;
  assign any_gnt = gnt_a | gnt_b;

  // Unsigned wrap makes addresses below the base fail the range check too.
  assign addr     = gnt_b ? b_addr_i : a_addr_i;
  assign offset   = addr - MemBase;
  assign in_range = offset < 32'(MemSize);
  assign we       = gnt_b & b_we_i;
  assign acc_err  = !in_range || (ReadOnly && we);

  assign mem_req_o   = any_gnt && !acc_err;
  assign mem_we_o    = we;
  assign mem_be_o    = gnt_b ? b_be_i : 4'hF;
  assign mem_addr_o  = addr;
  assign mem_wdata_o = gnt_b ? b_wdata_i : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      lerr_q  <= 1'b0;
      wr_q    <= 1'b0;
      owner_q <= HOST_A;
      proto_q <= 1'b0;
    end else begin
      pend_q <= mem_req_o;
      lerr_q <= any_gnt && acc_err;
      wr_q   <= mem_req_o && we;
      if (any_gnt) owner_q <= gnt_b ? HOST_B : HOST_A;
      if (mem_rvalid_i && !pend_q) proto_q <= 1'b1;
    end
  end

  // Writes still get a response, but never carry read data back.
  assign fwd_rsp   = pend_q && mem_rvalid_i;
  assign rsp_valid = fwd_rsp || lerr_q;
  assign rsp_data  = (fwd_rsp && !wr_q) ? mem_rdata_i : 32'h0;

  assign a_rvalid_o  = rsp_valid && (owner_q == HOST_A);
  assign a_err_o     = lerr_q && (owner_q == HOST_A);
  assign a_rdata_o   = (owner_q == HOST_A) ? rsp_data : 32'h0;
  assign b_rvalid_o  = rsp_valid && (owner_q == HOST_B);
  assign b_err_o     = lerr_q && (owner_q == HOST_B);
  assign b_rdata_o   = (owner_q == HOST_B) ? rsp_data : 32'h0;
  assign proto_err_o = proto_q;

endmodule
